// File: rtl/xiyiji_pkg.sv
// Washing-machine controller shared types: state codes, program codes,
// actuator bundle, default durations and per-program helpers.
package xiyiji_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned MODE_W  = 2;
  localparam int unsigned COUNT_W = 6;
  localparam int unsigned TIME_W  = 4;
  localparam int unsigned TMP_W   = 2;

  localparam int unsigned T_INLET_DEF = 5;
  localparam int unsigned T_RUN_DEF   = 4;
  localparam int unsigned T_PAUSE_DEF = 1;
  localparam int unsigned T_DRAIN_DEF = 5;
  localparam int unsigned T_DRY_DEF   = 6;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 4'd0,
    ST_INLET  = 4'd1,
    ST_FWD    = 4'd2,
    ST_PAUSE1 = 4'd3,
    ST_REV    = 4'd4,
    ST_PAUSE2 = 4'd5,
    ST_DRAIN  = 4'd6,
    ST_DRY    = 4'd7,
    ST_DONE   = 4'd8,
    ST_EMERG  = 4'd9
  } state_e;

  typedef enum logic [MODE_W-1:0] {
    MODE_FULL  = 2'd0,
    MODE_WASH  = 2'd1,
    MODE_RINSE = 2'd2,
    MODE_DRY   = 2'd3
  } mode_e;

  typedef struct packed {
    logic zheng;
    logic fan;
    logic inlet;
    logic drain;
    logic dry;
  } act_t;

  // Number of fwd/pause/rev/pause wash cycles in a program
  function automatic logic [TMP_W-1:0] mode_cycles(input logic [MODE_W-1:0] m);
    case (m)
      MODE_FULL, MODE_WASH: return TMP_W'(3);
      MODE_RINSE:           return TMP_W'(1);
      default:              return TMP_W'(0);
    endcase
  endfunction

  // Every program except dry-only starts by filling with water
  function automatic logic mode_has_inlet(input logic [MODE_W-1:0] m);
    return (m != MODE_DRY);
  endfunction

  // Full and dry-only programs end with a spin-dry phase
  function automatic logic mode_has_dry(input logic [MODE_W-1:0] m);
    return (m == MODE_FULL) || (m == MODE_DRY);
  endfunction

  // Total program length in seconds for the given phase durations
  function automatic logic [COUNT_W-1:0] mode_total(input logic [MODE_W-1:0] m,
                                                    input int unsigned t_inlet,
                                                    input int unsigned t_run,
                                                    input int unsigned t_pause,
                                                    input int unsigned t_drain,
                                                    input int unsigned t_dry);
    int unsigned sum;
    sum = 32'(mode_cycles(m)) * (2 * t_run + 2 * t_pause) + t_drain;
    if (mode_has_inlet(m)) sum = sum + t_inlet;
    if (mode_has_dry(m))   sum = sum + t_dry;
    return COUNT_W'(sum);
  endfunction

endpackage

// File: rtl/xiyiji_tick_gen.sv
// One-second tick generator: registered one-clock pulse every TICK_DIV clocks
// (constantly high when TICK_DIV is 1).
module xiyiji_tick_gen
  import xiyiji_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((TICK_DIV > 1) ? (TICK_DIV - 1) : 0);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Divider count and the pulse that lines up with its terminal value
  always_comb begin
    cnt_d  = (cnt_q == LAST) ? '0 : CNT_W'(cnt_q + 1'b1);
    tick_d = (cnt_d == LAST);
  end

  // Divider registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      tick_q <= (LAST == '0);
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/xiyiji_washer.sv
// Washing-machine program controller: select cycles through four programs,
// a start edge runs the chosen one as a timed phase sequence, emergency
// parks the machine in an alarm state.
// Optional build macro XIYIJI_DONE_ALARM_EN: beep alarm for 3 ticks on DONE entry.
module xiyiji_washer
  import xiyiji_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned T_INLET  = T_INLET_DEF,
  parameter int unsigned T_RUN    = T_RUN_DEF,
  parameter int unsigned T_PAUSE  = T_PAUSE_DEF,
  parameter int unsigned T_DRAIN  = T_DRAIN_DEF,
  parameter int unsigned T_DRY    = T_DRY_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               select,
  input  logic               start,
  input  logic               emergency,
  output logic               zheng,
  output logic               fan,
  output logic               inlet,
  output logic               drain,
  output logic               dry,
  output logic               ledzheng,
  output logic               ledfan,
  output logic               ledinlet,
  output logic               leddrain,
  output logic               leddry,
  output logic               ledstop,
  output logic               alarm,
  output logic [MODE_W-1:0]  mode_c,
  output logic [COUNT_W-1:0] count,
  output logic [STATE_W-1:0] c_s,
  output logic [TIME_W-1:0]  time_c,
  output logic               enable,
  output logic [TMP_W-1:0]   tmp
);

  state_e             state_q, state_d, adv_s;
  logic [MODE_W-1:0]  mode_q, mode_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [TIME_W-1:0]  time_q, time_d;
  logic [TMP_W-1:0]   tmp_q, tmp_d;
  logic               enable_q, enable_d;
  act_t               act_q, act_d;
  logic               ledstop_q, ledstop_d;
  logic               alarm_q, alarm_d;
  logic               select_q, start_q;
  logic               sel_edge, start_edge;
  logic               tick;
  logic               beep_on;

  xiyiji_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_i  (clk),
    .rst_i  (rst),
    .tick_o (tick)
  );

  assign sel_edge   = select & ~select_q;
  assign start_edge = start & ~start_q;

  // Seconds spent in each timed phase
  function automatic logic [TIME_W-1:0] dur(input state_e s);
    case (s)
      ST_INLET:             return TIME_W'(T_INLET);
      ST_FWD, ST_REV:       return TIME_W'(T_RUN);
      ST_PAUSE1, ST_PAUSE2: return TIME_W'(T_PAUSE);
      ST_DRAIN:             return TIME_W'(T_DRAIN);
      ST_DRY:               return TIME_W'(T_DRY);
      default:              return '0;
    endcase
  endfunction

  // Next-state, counters and decoded actuator outputs
  always_comb begin
    state_d  = state_q;
    adv_s    = state_q;
    mode_d   = mode_q;
    count_d  = count_q;
    time_d   = time_q;
    tmp_d    = tmp_q;
    enable_d = enable_q;
    act_d    = '0;

    if (sel_edge && !enable_q) mode_d = MODE_W'(mode_q + 1'b1);

    if (emergency) begin
      state_d  = ST_EMERG;
      enable_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_edge) begin
            state_d  = mode_has_inlet(mode_q) ? ST_INLET : ST_DRAIN;
            time_d   = mode_has_inlet(mode_q) ? dur(ST_INLET) : dur(ST_DRAIN);
            count_d  = mode_total(mode_q, T_INLET, T_RUN, T_PAUSE, T_DRAIN, T_DRY);
            tmp_d    = '0;
            enable_d = 1'b1;
          end
        end
        ST_EMERG: begin
          state_d  = ST_IDLE;
          count_d  = '0;
          time_d   = '0;
          enable_d = 1'b0;
        end
        default: begin
          if (tick) begin
            count_d = COUNT_W'(count_q - 1'b1);
            time_d  = TIME_W'(time_q - 1'b1);
            if (time_q == TIME_W'(1)) begin
              case (state_q)
                ST_INLET:  adv_s = ST_FWD;
                ST_FWD:    adv_s = ST_PAUSE1;
                ST_PAUSE1: adv_s = ST_REV;
                ST_REV:    adv_s = ST_PAUSE2;
                ST_PAUSE2: begin
                  tmp_d = TMP_W'(tmp_q + 1'b1);
                  adv_s = ((3'(tmp_q) + 3'd1) < 3'(mode_cycles(mode_q))) ? ST_FWD : ST_DRAIN;
                end
                ST_DRAIN:  adv_s = mode_has_dry(mode_q) ? ST_DRY : ST_DONE;
                ST_DRY:    adv_s = ST_DONE;
                default:   adv_s = ST_IDLE;
              endcase
              state_d = adv_s;
              time_d  = dur(adv_s);
              if (adv_s == ST_DONE) begin
                count_d  = '0;
                enable_d = 1'b0;
              end
            end
          end
        end
      endcase
    end

    case (state_d)
      ST_INLET: act_d.inlet = 1'b1;
      ST_FWD:   act_d.zheng = 1'b1;
      ST_REV:   act_d.fan   = 1'b1;
      ST_DRAIN: act_d.drain = 1'b1;
      ST_DRY:   act_d.dry   = 1'b1;
      default:  act_d       = '0;
    endcase

    ledstop_d = (state_d == ST_IDLE) || (state_d == ST_DONE) || (state_d == ST_EMERG);
  end

`ifdef XIYIJI_DONE_ALARM_EN
  logic [1:0] beep_q, beep_d;

  // Beep countdown: armed on DONE entry, drains one step per tick while parked in DONE
  always_comb begin
    beep_d = '0;
    if (state_d == ST_DONE) begin
      if (state_q != ST_DONE)             beep_d = 2'd3;
      else if (tick && (beep_q != 2'd0))  beep_d = 2'(beep_q - 2'd1);
      else                                beep_d = beep_q;
    end
  end

  // Beep countdown register
  always_ff @(posedge clk) begin
    if (rst) beep_q <= '0;
    else     beep_q <= beep_d;
  end

  assign beep_on = (beep_d != 2'd0);
`else
  assign beep_on = 1'b0;
`endif

  assign alarm_d = (state_d == ST_EMERG) | beep_on;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= '0;
      count_q   <= '0;
      time_q    <= '0;
      tmp_q     <= '0;
      enable_q  <= 1'b0;
      act_q     <= '0;
      ledstop_q <= 1'b1;
      alarm_q   <= 1'b0;
      select_q  <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      count_q   <= count_d;
      time_q    <= time_d;
      tmp_q     <= tmp_d;
      enable_q  <= enable_d;
      act_q     <= act_d;
      ledstop_q <= ledstop_d;
      alarm_q   <= alarm_d;
      select_q  <= select;
      start_q   <= start;
    end
  end

  assign zheng    = act_q.zheng;
  assign fan      = act_q.fan;
  assign inlet    = act_q.inlet;
  assign drain    = act_q.drain;
  assign dry      = act_q.dry;
  assign ledzheng = act_q.zheng;
  assign ledfan   = act_q.fan;
  assign ledinlet = act_q.inlet;
  assign leddrain = act_q.drain;
  assign leddry   = act_q.dry;
  assign ledstop  = ledstop_q;
  assign alarm    = alarm_q;
  assign mode_c   = mode_q;
  assign count    = count_q;
  assign c_s      = state_q;
  assign time_c   = time_q;
  assign enable   = enable_q;
  assign tmp      = tmp_q;

endmodule

// File: tb/tb_xiyiji_washer.sv
// Bench for xiyiji_washer: directed program runs plus randomized runs with
// select/start noise and emergency aborts, checked against a phase-list model.
// Honours XIYIJI_DONE_ALARM_EN for the DONE beep expectation.
module tb_xiyiji_washer;

  logic       clk = 1'b0;
  logic       rst, select, start, emergency;
  logic       zheng, fan, inlet, drain, dry;
  logic       ledzheng, ledfan, ledinlet, leddrain, leddry, ledstop, alarm;
  logic [1:0] mode_c;
  logic [5:0] count;
  logic [3:0] c_s;
  logic [3:0] time_c;
  logic       enable;
  logic [1:0] tmp;

  int checks = 0;
  int errors = 0;
  int mode_m;
  int seg_st[$];
  int seg_du[$];

  xiyiji_washer dut (
    .clk(clk), .rst(rst), .select(select), .start(start), .emergency(emergency),
    .zheng(zheng), .fan(fan), .inlet(inlet), .drain(drain), .dry(dry),
    .ledzheng(ledzheng), .ledfan(ledfan), .ledinlet(ledinlet), .leddrain(leddrain),
    .leddry(leddry), .ledstop(ledstop), .alarm(alarm), .mode_c(mode_c), .count(count),
    .c_s(c_s), .time_c(time_c), .enable(enable), .tmp(tmp)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Program as an ordered list of (state code, seconds) phases
  task automatic build(input int m);
    int n;
    seg_st.delete();
    seg_du.delete();
    if (m != 3) begin seg_st.push_back(1); seg_du.push_back(5); end
    n = (m <= 1) ? 3 : ((m == 2) ? 1 : 0);
    for (int c = 0; c < n; c++) begin
      seg_st.push_back(2); seg_du.push_back(4);
      seg_st.push_back(3); seg_du.push_back(1);
      seg_st.push_back(4); seg_du.push_back(4);
      seg_st.push_back(5); seg_du.push_back(1);
    end
    seg_st.push_back(6); seg_du.push_back(5);
    if (m == 0 || m == 3) begin seg_st.push_back(7); seg_du.push_back(6); end
  endtask

  // {zheng,fan,inlet,drain,dry} expected for a state code
  function automatic logic [4:0] exp_act(input int s);
    case (s)
      1:       return 5'b00100;
      2:       return 5'b10000;
      4:       return 5'b01000;
      6:       return 5'b00010;
      7:       return 5'b00001;
      default: return 5'b00000;
    endcase
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_c_s"}, 32'(c_s), 0);
    chk({tag, "_mode"}, 32'(mode_c), 0);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_time"}, 32'(time_c), 0);
    chk({tag, "_tmp"}, 32'(tmp), 0);
    chk({tag, "_enable"}, 32'(enable), 0);
    chk({tag, "_ledstop"}, 32'(ledstop), 1);
    chk({tag, "_alarm"}, 32'(alarm), 0);
    chk({tag, "_act"}, 32'({zheng, fan, inlet, drain, dry}), 0);
  endtask

  task automatic do_select(input int n);
    for (int i = 0; i < n; i++) begin
      select = 1'b1; step();
      select = 1'b0; step();
      mode_m = (mode_m + 1) % 4;
    end
    chk("sel_mode", 32'(mode_c), 32'(mode_m));
  endtask

  // Expected outputs j seconds after program start
  task automatic check_running(input int j, input int total);
    int acc = 0;
    int st = 0;
    int tc = 0;
    int tp = 0;
    bit found = 1'b0;
    for (int i = 0; i < seg_st.size(); i++) begin
      if (!found) begin
        if (j < acc + seg_du[i]) begin
          st = seg_st[i];
          tc = acc + seg_du[i] - j;
          found = 1'b1;
        end else if (seg_st[i] == 5) begin
          tp++;
        end
      end
      acc += seg_du[i];
    end
    chk("run_c_s", 32'(c_s), 32'(st));
    chk("run_count", 32'(count), 32'(total - j));
    chk("run_time", 32'(time_c), 32'(tc));
    chk("run_tmp", 32'(tmp), 32'(tp));
    chk("run_enable", 32'(enable), 1);
    chk("run_ledstop", 32'(ledstop), 0);
    chk("run_alarm", 32'(alarm), 0);
    chk("run_act", 32'({zheng, fan, inlet, drain, dry}), 32'(exp_act(st)));
    chk("run_led", 32'({ledzheng, ledfan, ledinlet, leddrain, leddry}), 32'(exp_act(st)));
    chk("run_mode", 32'(mode_c), 32'(mode_m));
  endtask

  // abort_at: -1 run to completion, -2 abort at a random second, else abort there
  task automatic run_prog(input int abort_at, input bit noisy);
    int total = 0;
    bit aborted = 1'b0;
    build(mode_m);
    foreach (seg_du[i]) total += seg_du[i];
    if (abort_at == -2) abort_at = $urandom_range(0, total - 1);
    start = 1'b1;
    step();
    for (int j = 0; j < total && !aborted; j++) begin
      check_running(j, total);
      if (j == abort_at) begin
        select = 1'b0; start = 1'b0; emergency = 1'b1;
        step();
        chk("emerg_c_s", 32'(c_s), 9);
        chk("emerg_alarm", 32'(alarm), 1);
        chk("emerg_act", 32'({zheng, fan, inlet, drain, dry}), 0);
        chk("emerg_zheng", 32'(zheng), 0);
        chk("emerg_enable", 32'(enable), 0);
        chk("emerg_count", 32'(count), 32'(total - j));
        chk("emerg_ledstop", 32'(ledstop), 1);
        step();
        chk("emerg_hold_c_s", 32'(c_s), 9);
        chk("emerg_hold_count", 32'(count), 32'(total - j));
        emergency = 1'b0;
        step();
        chk("release_c_s", 32'(c_s), 0);
        chk("release_count", 32'(count), 0);
        chk("release_alarm", 32'(alarm), 0);
        chk("release_ledstop", 32'(ledstop), 1);
        chk("release_mode", 32'(mode_c), 32'(mode_m));
        aborted = 1'b1;
      end else begin
        if (noisy && j < total - 2) begin
          select = 1'($urandom % 2);
          start  = 1'($urandom % 2);
        end else begin
          select = 1'b0;
          start  = 1'b0;
        end
        step();
      end
    end
    if (!aborted) begin
      for (int k = 0; k < 4; k++) begin
        chk("done_c_s", 32'(c_s), 8);
        chk("done_count", 32'(count), 0);
        chk("done_time", 32'(time_c), 0);
        chk("done_enable", 32'(enable), 0);
        chk("done_ledstop", 32'(ledstop), 1);
        chk("done_act", 32'({zheng, fan, inlet, drain, dry}), 0);
`ifdef XIYIJI_DONE_ALARM_EN
        chk("done_alarm", 32'(alarm), (k < 3) ? 1 : 0);
`else
        chk("done_alarm", 32'(alarm), 0);
`endif
        step();
      end
    end
  endtask

  initial begin
    rst = 1'b1; select = 1'b0; start = 1'b0; emergency = 1'b0; mode_m = 0;
    repeat (2) step();
    chk_reset("reset");
    rst = 1'b0;
    step();

    do_select(2);                 // rinse
    run_prog(-1, 1'b0);
    do_select(2);                 // wraps 3 -> 0, full program
    run_prog(-1, 1'b1);           // select/start noise while running
    run_prog(5, 1'b0);            // emergency during first FWD
    do_select(3);                 // dry-only
    run_prog(-1, 1'b0);
    do_select(4);                 // four edges land back on dry-only
    run_prog(-1, 1'b0);

    // Reset in the middle of a program
    start = 1'b1; step();
    start = 1'b0; repeat (3) step();
    rst = 1'b1; step();
    chk_reset("midrst");
    rst = 1'b0; mode_m = 0;
    step();

    repeat (10) begin
      do_select($urandom_range(0, 3));
      run_prog(($urandom % 3 == 0) ? -2 : -1, 1'($urandom % 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
